alu_ctrl_md: RTL
================

// Module: alu_ctrl_md
// PURPOSE
//  Next-generation ALU control for the execute stage. Decodes i_op/i_func into the
//  4-bit ALU control code (`OP_*/`FUNC_*/`ALU_* from defs.v) as a registered output.
//  It also owns an iterative unsigned multiply/divide unit: MUL/DIV/MOD run over
//  WIDTH cycles under a pipeline stall. Unknown functs raise o_illegal and never hold stale codes.
// PARAMETERS
//  WIDTH   32  operand/result width; MD latency scales with it (>=4)
//  OP_W    4   opcode field width
//  FUNC_W  10  function field width
// PORTS
//  i_clk        in   1       clock; all state on rising edge
//  i_rst        in   1       synchronous reset, active-high
//  i_valid      in   1       instruction present in issue cycle
//  i_op         in   OP_W    opcode
//  i_func       in   FUNC_W  function field (meaningful when i_op==`OP_RTYPE)
//  i_a          in   WIDTH   operand A (dividend/multiplicand)
//  i_b          in   WIDTH   operand B (divisor/multiplier)
//  o_aluctl     out  4       registered ALU control code
//  o_illegal    out  1       registered; 1 for the cycle after an unknown RTYPE funct issues
//  o_stall      out  1       registered; 1 while MD unit busy, pipeline must hold
//  o_md_valid   out  1       one-cycle pulse, o_md_result valid
//  o_md_result  out  WIDTH   MD result; held until next MD completion
//  o_md_dz      out  1       registered with o_md_valid: divisor was zero
// BEHAVIOUR
//  Reset: o_aluctl=`ALU_ADD, o_illegal=0, o_stall=0, o_md_valid=0, o_md_result=0,
//   o_md_dz=0, FSM=IDLE, counter=0. Reset in any state aborts the MD op; no md_valid pulse.
//  Decode (cycle N, i_valid=1, FSM=IDLE) -> regs at N+1:
//   - i_op!=`OP_RTYPE: `ALU_ADD. RTYPE: JIE/JIER->SIE, JIL/JILR->SIL, OR/AND/XOR/NOR/
//     SUB/ADD/MUL/DIV/MOD/SLL/SLA/SRL/SRA -> same-named `ALU_* code.
//   - unknown funct: o_aluctl=`ALU_ADD, o_illegal=1 (one cycle), no MD start.
//   - i_valid=0: o_aluctl holds, o_illegal=0.
//  FSM states: IDLE, MUL, DIV, DONE.
//   IDLE->MUL on MUL issue; latch a,b; acc=0; cnt=WIDTH.
//   IDLE->DIV on DIV/MOD issue with b!=0; latch a,b,sel; rem=0; cnt=WIDTH.
//   IDLE->DONE on DIV/MOD issue with b==0 (fast path, dz=1).
//   MUL: shift-add, one multiplier bit per cycle, LSB first; cnt-- ; cnt==1 -> DONE.
//   DIV: restoring, one quotient bit per cycle, MSB first; cnt-- ; cnt==1 -> DONE.
//   DONE: o_md_valid=1 for exactly this cycle, o_stall=0, ->IDLE.
//  Latency: MD issue at N -> o_stall=1 for N+1..N+WIDTH, o_md_valid at N+WIDTH+1.
//   Divide-by-zero: o_stall never asserted; o_md_valid and o_md_dz at N+1.
//  Results (unsigned): MUL = low WIDTH bits of a*b (overflow silently truncated);
//   DIV = floor(a/b); MOD = a mod b. b==0: DIV -> all ones, MOD -> a.
//  While FSM!=IDLE: i_valid ignored (pipeline is stalled); o_aluctl holds the MD code.
//  Back-to-back: i_valid accepted in DONE cycle? No - only in IDLE; a new issue may
//   coincide with the cycle after o_md_valid.
//  o_md_result/o_md_dz update only in DONE; hold otherwise.
// TESTING (WIDTH=8 unless noted)
//  Reset: assert i_rst 2 cycles -> all outputs zero/`ALU_ADD, o_stall=0.
//  Decode: RTYPE FUNC_SUB -> o_aluctl=`ALU_SUB at N+1; op!=RTYPE -> `ALU_ADD; bad funct
//   0x3FF -> o_illegal=1 one cycle, o_aluctl=`ALU_ADD, o_stall=0.
//  MUL 200*3 -> o_stall N+1..N+8, o_md_valid at N+9, result 88 (600 mod 256); 7*6 -> 42.
//  DIV 100/7 -> 14, MOD 100%7 -> 2, each md_valid at N+9; 255/1 -> 255; DIV 5/9 -> 0.
//  Div-by-zero: DIV 37/0 -> md_valid+dz at N+1, result 255; MOD 37/0 -> 37, no stall.
//  Reset at N+4 of MUL -> o_stall=0 next cycle, no md_valid; i_valid with ADD during
//   busy is ignored (o_aluctl stays `ALU_MUL); WIDTH=32 MUL 0xFFFF*0x10001 -> 0xFFFFFFFF at N+33.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: execute-stage ALU control decode with an iterative unsigned multiply/divide unit
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid, i_op, i_func instruction issue (decoded only while the MD unit is idle)
//   i_a, i_b              MD operands (dividend/multiplicand, divisor/multiplier)
//   o_aluctl, o_illegal   registered ALU control code, one-cycle unknown-funct flag
//   o_stall               high while a multi-cycle MD op is in flight
//   o_md_valid            one-cycle completion pulse
//   o_md_result, o_md_dz  MD result and divide-by-zero flag, held until the next completion
// Encodings (OP_RTYPE, FUNC_*, ALU_*) are the localparams below.
module alu_ctrl_md #(
    parameter int WIDTH  = 32,
    parameter int OP_W   = 4,
    parameter int FUNC_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [OP_W-1:0]   i_op,
    input  logic [FUNC_W-1:0] i_func,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [3:0]        o_aluctl,
    output logic              o_illegal,
    output logic              o_stall,
    output logic              o_md_valid,
    output logic [WIDTH-1:0]  o_md_result,
    output logic              o_md_dz
);
    localparam logic [OP_W-1:0] OP_RTYPE = '0;
    localparam logic [FUNC_W-1:0] FUNC_SLL  = FUNC_W'(10'h000);
    localparam logic [FUNC_W-1:0] FUNC_SLA  = FUNC_W'(10'h001);
    localparam logic [FUNC_W-1:0] FUNC_SRL  = FUNC_W'(10'h002);
    localparam logic [FUNC_W-1:0] FUNC_SRA  = FUNC_W'(10'h003);
    localparam logic [FUNC_W-1:0] FUNC_JIE  = FUNC_W'(10'h008);
    localparam logic [FUNC_W-1:0] FUNC_JIER = FUNC_W'(10'h009);
    localparam logic [FUNC_W-1:0] FUNC_JIL  = FUNC_W'(10'h00A);
    localparam logic [FUNC_W-1:0] FUNC_JILR = FUNC_W'(10'h00B);
    localparam logic [FUNC_W-1:0] FUNC_MUL  = FUNC_W'(10'h018);
    localparam logic [FUNC_W-1:0] FUNC_DIV  = FUNC_W'(10'h01A);
    localparam logic [FUNC_W-1:0] FUNC_MOD  = FUNC_W'(10'h01B);
    localparam logic [FUNC_W-1:0] FUNC_ADD  = FUNC_W'(10'h020);
    localparam logic [FUNC_W-1:0] FUNC_SUB  = FUNC_W'(10'h022);
    localparam logic [FUNC_W-1:0] FUNC_AND  = FUNC_W'(10'h024);
    localparam logic [FUNC_W-1:0] FUNC_OR   = FUNC_W'(10'h025);
    localparam logic [FUNC_W-1:0] FUNC_XOR  = FUNC_W'(10'h026);
    localparam logic [FUNC_W-1:0] FUNC_NOR  = FUNC_W'(10'h027);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SLA = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SRA = 4'd9;
    localparam logic [3:0] ALU_SIE = 4'd10;
    localparam logic [3:0] ALU_SIL = 4'd11;
    localparam logic [3:0] ALU_MUL = 4'd12;
    localparam logic [3:0] ALU_DIV = 4'd13;
    localparam logic [3:0] ALU_MOD = 4'd14;

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sel_q, sel_d;
    logic [3:0]       aluctl_q, aluctl_d;
    logic             illegal_q, illegal_d;
    logic             stall_q, stall_d;
    logic             md_valid_q, md_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             dz_q, dz_d;

    logic [3:0]       dec_code;
    logic             dec_legal;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quot_n;
    logic             last;
    logic             is_dm;

    always_comb begin
        dec_code  = ALU_ADD;
        dec_legal = 1'b1;
        if (i_op == OP_RTYPE) begin
            case (i_func)
                FUNC_JIE, FUNC_JIER: dec_code = ALU_SIE;
                FUNC_JIL, FUNC_JILR: dec_code = ALU_SIL;
                FUNC_OR:             dec_code = ALU_OR;
                FUNC_AND:            dec_code = ALU_AND;
                FUNC_XOR:            dec_code = ALU_XOR;
                FUNC_NOR:            dec_code = ALU_NOR;
                FUNC_SUB:            dec_code = ALU_SUB;
                FUNC_ADD:            dec_code = ALU_ADD;
                FUNC_MUL:            dec_code = ALU_MUL;
                FUNC_DIV:            dec_code = ALU_DIV;
                FUNC_MOD:            dec_code = ALU_MOD;
                FUNC_SLL:            dec_code = ALU_SLL;
                FUNC_SLA:            dec_code = ALU_SLA;
                FUNC_SRL:            dec_code = ALU_SRL;
                FUNC_SRA:            dec_code = ALU_SRA;
                default:             dec_legal = 1'b0;
            endcase
        end
    end

    // Shift-add step: x is the multiplicand shifting left, y the multiplier shifting right.
    // Restoring-divide step: x shifts the dividend out MSB-first and the quotient in LSB-first,
    // acc holds the partial remainder, y the divisor.
    always_comb begin
        mul_acc = acc_q + (y_q[0] ? x_q : '0);
        trial   = {acc_q, x_q[WIDTH-1]};
        diff    = trial - {1'b0, y_q};
        ge      = trial >= {1'b0, y_q};
        rem_n   = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_n  = {x_q[WIDTH-2:0], ge};
        last    = cnt_q == CW'(1);
        is_dm   = dec_code == ALU_DIV || dec_code == ALU_MOD;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        acc_d      = acc_q;
        sel_d      = sel_q;
        aluctl_d   = aluctl_q;
        illegal_d  = 1'b0;
        stall_d    = 1'b0;
        md_valid_d = 1'b0;
        result_d   = result_q;
        dz_d       = dz_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    aluctl_d  = dec_code;
                    illegal_d = !dec_legal;
                    if (dec_code == ALU_MUL || (is_dm && i_b != '0)) begin
                        state_d = dec_code == ALU_MUL ? S_MUL : S_DIV;
                        sel_d   = dec_code == ALU_MOD;
                        x_d     = i_a;
                        y_d     = i_b;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        stall_d = 1'b1;
                    end else if (is_dm) begin
                        // Divide by zero resolves in one cycle without stalling.
                        state_d    = S_DONE;
                        sel_d      = dec_code == ALU_MOD;
                        md_valid_d = 1'b1;
                        dz_d       = 1'b1;
                        result_d   = dec_code == ALU_MOD ? i_a : '1;
                    end
                end
            end
            S_MUL: begin
                x_d     = x_q << 1;
                y_d     = y_q >> 1;
                acc_d   = mul_acc;
                cnt_d   = cnt_q - CW'(1);
                state_d = last ? S_DONE : S_MUL;
                stall_d = !last;
                if (last) begin
                    md_valid_d = 1'b1;
                    dz_d       = 1'b0;
                    result_d   = mul_acc;
                end
            end
            S_DIV: begin
                x_d     = quot_n;
                acc_d   = rem_n;
                cnt_d   = cnt_q - CW'(1);
                state_d = last ? S_DONE : S_DIV;
                stall_d = !last;
                if (last) begin
                    md_valid_d = 1'b1;
                    dz_d       = 1'b0;
                    result_d   = sel_q ? rem_n : quot_n;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            acc_q      <= '0;
            sel_q      <= 1'b0;
            aluctl_q   <= ALU_ADD;
            illegal_q  <= 1'b0;
            stall_q    <= 1'b0;
            md_valid_q <= 1'b0;
            result_q   <= '0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            acc_q      <= acc_d;
            sel_q      <= sel_d;
            aluctl_q   <= aluctl_d;
            illegal_q  <= illegal_d;
            stall_q    <= stall_d;
            md_valid_q <= md_valid_d;
            result_q   <= result_d;
            dz_q       <= dz_d;
        end
    end

    assign o_aluctl    = aluctl_q;
    assign o_illegal   = illegal_q;
    assign o_stall     = stall_q;
    assign o_md_valid  = md_valid_q;
    assign o_md_result = result_q;
    assign o_md_dz     = dz_q;
endmodule
